// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte from the host to a PS/2 device, such as 0xED
// followed by an LED mask, or 0xFF for reset. The block:
//   - inhibits the clock to make the request-to-send;
//   - presents the start bit, 8 data bits (LSB first), odd parity and the stop bit
//     on device-generated falling clock edges;
//   - samples the device acknowledge bit.
// tx_idle gates the keyboard receiver that shares the same pins, so the
// receiver ignores the host's own frame.
//
// Optional feature: define PS2_TX_TIMEOUT_EN to build a watchdog that aborts
// a frame when the device stops clocking for TIMEOUT_CYCLES cycles.
//
// Parameters:
//   RTS_CYCLES     clock-inhibit pulse length, in clk cycles
//   FILTER_LEN     glitch-filter depth on ps2c/ps2d, in samples
//   TIMEOUT_CYCLES watchdog limit in clk cycles (PS2_TX_TIMEOUT_EN only)
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   wr_ps2       one-cycle start strobe, honoured only when idle
//   din          command byte, sampled with wr_ps2
//   ps2c, ps2d   open-drain PS/2 clock and data (driven 0 or released to z)
//   tx_idle      high only while idle
//   tx_done_tick one-cycle pulse when a frame completes
//   tx_nack      device acknowledge bit of the last frame was 1
//   tx_timeout   one-cycle pulse when the watchdog aborts a frame

module ps2_host_tx #(
    parameter int RTS_CYCLES     = 10000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_nack,
    output logic       tx_timeout
);

    localparam int RW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, RTS, START, DATA, STOP, ACK, WAIT_REL
    } state_t;

    state_t                state_reg, state_next;
    logic [8:0]            packet_reg, packet_next;
    logic [3:0]            n_reg, n_next;
    logic [RW-1:0]         rts_cnt_reg, rts_cnt_next;
    logic                  nack_next, done_next;

    logic [FILTER_LEN-1:0] filt_c_reg, filt_d_reg;
    logic                  f_c_reg, f_d_reg, f_c_next, f_d_next;
    logic                  fall;
    logic                  c_low, d_low;

    // ------------------------------------------------------------------
    // Glitch filter. Each filtered level changes only after FILTER_LEN
    // identical samples. Reset fills the filters with ones, which is the
    // idle-bus level, so no spurious edge appears after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_c_reg <= '1;
            filt_d_reg <= '1;
            f_c_reg    <= 1'b1;
            f_d_reg    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            filt_c_reg <= {ps2c, filt_c_reg[FILTER_LEN-1:1]};
            filt_d_reg <= {ps2d, filt_d_reg[FILTER_LEN-1:1]};
            f_c_reg    <= f_c_next;
            f_d_reg    <= f_d_next;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves a variable unassigned would infer a latch.
        f_c_next = f_c_reg;
        f_d_next = f_d_reg;
        if (filt_c_reg == '1)      f_c_next = 1'b1;
        else if (filt_c_reg == '0) f_c_next = 1'b0;
        if (filt_d_reg == '1)      f_d_next = 1'b1;
        else if (filt_d_reg == '0) f_d_next = 1'b0;
    end

    // The host's own clock inhibit also produces a fall tick. It arrives
    // in RTS, which ignores fall, so it is harmless.
    assign fall = f_c_reg & ~f_c_next;

`ifdef PS2_TX_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Watchdog: counts cycles while the device is expected to be clocking,
    // and restarts on every device falling edge.
    // ------------------------------------------------------------------
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_reg;
    logic          wd_active, wd_expired;

    assign wd_active  = (state_reg == START) || (state_reg == DATA) ||
                        (state_reg == STOP)  || (state_reg == ACK);
    assign wd_expired = wd_active && !fall &&
                        (wd_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_reg     <= '0;
            tx_timeout <= 1'b0;
        end else begin
            tx_timeout <= wd_expired;
            if (!wd_active || fall || wd_expired) wd_reg <= '0;
            else                                  wd_reg <= wd_reg + 1'b1;
        end
    end
`else
    assign tx_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transmit FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            packet_reg   <= '0;
            n_reg        <= '0;
            rts_cnt_reg  <= '0;
            tx_nack      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state_reg    <= state_next;
            packet_reg   <= packet_next;
            n_reg        <= n_next;
            rts_cnt_reg  <= rts_cnt_next;
            tx_nack      <= nack_next;
            tx_done_tick <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        packet_next  = packet_reg;
        n_next       = n_reg;
        rts_cnt_next = rts_cnt_reg;
        nack_next    = tx_nack;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (wr_ps2) begin
                    packet_next  = {~^din, din};  // odd parity in bit 8
                    n_next       = 4'd8;
                    rts_cnt_next = RW'(RTS_CYCLES - 1);
                    nack_next    = 1'b0;
                    state_next   = RTS;
                end
            end
            RTS: begin
                if (rts_cnt_reg == '0) state_next   = START;
                else                   rts_cnt_next = rts_cnt_reg - 1'b1;
            end
            START: begin
                if (fall) state_next = DATA;
            end
            DATA: begin
                // Bits 0..7 and the parity bit are presented in turn. The
                // ninth edge moves on without shifting.
                if (fall) begin
                    if (n_reg == 4'd0) begin
                        state_next = STOP;
                    end else begin
                        packet_next = {1'b0, packet_reg[8:1]};
                        n_next      = n_reg - 1'b1;
                    end
                end
            end
            STOP: begin
                if (fall) state_next = ACK;
            end
            ACK: begin
                if (fall) begin
                    nack_next  = f_d_reg;
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (f_c_reg && f_d_reg) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        if (wd_expired) state_next = IDLE;
`endif
    end

    // ------------------------------------------------------------------
    // Open-drain line drive, decoded from registered state only. Because
    // of that, an asynchronous reset releases both lines immediately.
    // ------------------------------------------------------------------
    always_comb begin
        c_low = 1'b0;
        d_low = 1'b0;
        case (state_reg)
            RTS: begin
                c_low = 1'b1;
                d_low = (rts_cnt_reg == '0);  // data low in the last inhibit cycle
            end
            START:   d_low = 1'b1;
            DATA:    d_low = ~packet_reg[0];
            default: ;
        endcase
    end

    assign ps2c    = c_low ? 1'b0 : 1'bz;
    assign ps2d    = d_low ? 1'b0 : 1'bz;
    assign tx_idle = (state_reg == IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx.
//
// A behavioural PS/2 device drives the open-drain clock and samples data
// before each falling edge. Expected frames come from the byte itself:
//   - a start bit of 0;
//   - the data bits, LSB first;
//   - an odd-parity bit taken from a population count;
//   - a stop bit of 1.
// The expected acknowledge comes from the value the device model chooses.

module tb_ps2_host_tx;

    localparam int RTS_CYCLES     = 1000;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 5000;
    localparam int HALF           = 30;   // device clock half-period, clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_idle, tx_done_tick, tx_nack, tx_timeout;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;

    wire ps2c;
    wire ps2d;
    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int to_cnt   = 0;
    int cyc      = 0;
    int fall_cyc = 0;

    ps2_host_tx #(
        .RTS_CYCLES    (RTS_CYCLES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_nack     (tx_nack),
        .tx_timeout  (tx_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_done_tick === 1'b1) done_cnt++;
        if (tx_timeout === 1'b1)   to_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame as the device should see it on the wire, index 0 first.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = (b >> i) & 8'h01;
        f[9]  = ($countones(b) % 2 == 0);   // total ones in data+parity is odd
        f[10] = 1'b1;
        return f;
    endfunction

    // Issue one command and play the device side.
    // abort_after > 0 stops after that many clock pulses and returns early.
    task automatic run_frame(input string tag, input logic [7:0] b,
                             input bit ack, input bit glitch, input bit busy,
                             input int abort_after);
        logic [10:0] cap, exp_f;
        int c_low, d_first, done_before, waited;
        exp_f       = model_frame(b);
        done_before = done_cnt;
        cap         = '0;

        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = 8'($urandom);
        check({tag, "_accept"}, {29'd0, tx_idle, tx_nack, ps2c}, 32'd0);

        // Measure the clock inhibit and the cycle in which data goes low.
        c_low   = 0;
        d_first = 0;
        for (int i = 0; i < RTS_CYCLES + 50; i++) begin
            if (ps2c !== 1'b0) break;
            c_low++;
            if (d_first == 0 && ps2d === 1'b0) d_first = c_low;
            @(negedge clk);
        end
        check({tag, "_rts_len"}, c_low, RTS_CYCLES);
        check({tag, "_rts_dlow"}, d_first, RTS_CYCLES);

        repeat (2 * HALF) @(negedge clk);

        for (int k = 0; k < 11; k++) begin
            cap[k]    = (ps2d !== 1'b0);
            dev_c_low = 1'b1;
            fall_cyc  = cyc;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            if (glitch && k >= 2 && k <= 9) begin
                repeat (HALF / 3) @(negedge clk);
                dev_c_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_c_low = 1'b0;
                repeat (HALF - HALF / 3 - 3) @(negedge clk);
            end else if (busy && k == 5) begin
                repeat (5) @(negedge clk);
                din    = 8'h55;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                repeat (HALF - 6) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (abort_after == k + 1) return;
        end

        check({tag, "_start"},  {31'd0, cap[0]},  {31'd0, exp_f[0]});
        check({tag, "_data"},   {24'd0, cap[8:1]}, {24'd0, b});
        check({tag, "_parity"}, {31'd0, cap[9]},  {31'd0, exp_f[9]});
        check({tag, "_stop"},   {31'd0, cap[10]}, {31'd0, exp_f[10]});

        // Acknowledge pulse: hold data for the whole 12th clock pulse.
        dev_d_low = !ack;
        repeat (HALF) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_d_low = 1'b0;

        waited = 0;
        while (done_cnt == done_before && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done_seen"}, {31'd0, done_cnt != done_before}, 32'd1);
        check({tag, "_nack"}, {31'd0, tx_nack}, {31'd0, ack});
        check({tag, "_idle"}, {31'd0, tx_idle}, 32'd1);
        repeat (20) @(negedge clk);
        check({tag, "_done_count"}, done_cnt - done_before, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {26'd0, tx_idle, tx_done_tick, tx_nack, tx_timeout, ps2c, ps2d},
              32'b100011);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_reset", {31'd0, tx_idle}, 32'd1);

        // Directed frames
        run_frame("normal_ed", 8'hED, 1'b0, 1'b0, 1'b0, 0);
        run_frame("nack_00",   8'h00, 1'b1, 1'b0, 1'b0, 0);
        run_frame("ff_clear",  8'hFF, 1'b0, 1'b0, 1'b0, 0);
        run_frame("busy_f4",   8'hF4, 1'b0, 1'b0, 1'b1, 0);
        run_frame("glitch_a5", 8'hA5, 1'b0, 1'b1, 1'b0, 0);

        // Reset in the middle of DATA (start bit plus 4 data bits clocked)
        run_frame("rst_mid", 8'h3C, 1'b0, 1'b0, 1'b0, 5);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_lines", {30'd0, ps2c, ps2d}, 32'b11);
        check("rst_mid_idle", {30'd0, tx_idle, tx_nack}, 32'b10);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        run_frame("after_rst_ed", 8'hED, 1'b0, 1'b0, 1'b0, 0);

        // Randomized frames
        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom),
                      1'($urandom), 1'b0, 0);
        end

`ifdef PS2_TX_TIMEOUT_EN
        begin
            int base_done, waited, delta;
            base_done = done_cnt;
            run_frame("timeout", 8'h96, 1'b0, 1'b0, 1'b0, 5);
            waited = 0;
            while (tx_timeout !== 1'b1 && waited < TIMEOUT_CYCLES + 200) begin
                @(negedge clk);
                waited++;
            end
            delta = cyc - fall_cyc;
            check("timeout_seen", {31'd0, tx_timeout}, 32'd1);
            check("timeout_delay", delta, TIMEOUT_CYCLES + FILTER_LEN + 1);
            check("timeout_lines", {29'd0, tx_idle, ps2c, ps2d}, 32'b111);
            @(negedge clk);
            check("timeout_pulse", {31'd0, tx_timeout}, 32'd0);
            repeat (50) @(negedge clk);
            check("timeout_no_done", done_cnt - base_done, 32'd0);
        end
`else
        check("timeout_tied_low", to_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
